// File: rtl/binning_nxn.sv
// binning_nxn: streaming KERNELxKERNEL pixel binner; reduces HRESxVRES raster video to (HRES/K)x(VRES/K).
// Latency: 1 cycle from the completing pixel (h_ph==K-1, v_ph==K-1) to the data_valid_out strobe.
// Backpressure: none; cycles with data_valid_in low stall all state, blanking must not be flagged valid.
//
// Ports:
//   clk_in, rst_in (async, active-high)
//   hcount_in / vcount_in / pixel_data_in / data_valid_in : raster input
//   pixel_data_out / hcount_out / vcount_out / data_valid_out : one strobe per completed block
// Optional: define BINNING_FRAME_STATS_EN to add frame_done_out and ones_count_out.
//
// MODE 0 outputs (block sum > THRESHOLD); MODE 1 outputs the truncated block mean.
module binning_nxn #(
    parameter  int HRES       = 1280,
    parameter  int VRES       = 720,
    parameter  int DATA_WIDTH = 1,
    parameter  int KERNEL     = 4,
    parameter  int MODE       = 0,
    parameter  int THRESHOLD  = 8,
    localparam int OUT_W      = (MODE == 1) ? DATA_WIDTH : 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [$clog2(HRES)-1:0]        hcount_in,
    input  logic [$clog2(VRES)-1:0]        vcount_in,
    input  logic [DATA_WIDTH-1:0]          pixel_data_in,
    input  logic                           data_valid_in,
    output logic [OUT_W-1:0]               pixel_data_out,
    output logic [$clog2(HRES/KERNEL)-1:0] hcount_out,
    output logic [$clog2(VRES/KERNEL)-1:0] vcount_out,
    output logic                           data_valid_out
`ifdef BINNING_FRAME_STATS_EN
    ,
    output logic                                            frame_done_out,
    output logic [$clog2(HRES*VRES/KERNEL/KERNEL+1)-1:0]   ones_count_out
`endif
);

    localparam int LK     = $clog2(KERNEL);
    localparam int SUM_W  = DATA_WIDTH + 2 * LK;
    localparam int RACC_W = DATA_WIDTH + LK;
    localparam int NCOL   = HRES / KERNEL;
    localparam int COL_W  = $clog2(NCOL);
    localparam int ROW_W  = $clog2(VRES / KERNEL);
    localparam logic [LK-1:0] PH_LAST = LK'(KERNEL - 1);
    localparam logic [31:0]   THR_U   = 32'(THRESHOLD);

    logic [LK-1:0]     w_h_ph;
    logic [LK-1:0]     w_v_ph;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_col_ok;

    logic [RACC_W-1:0] r_racc;
    logic [RACC_W-1:0] w_racc_next;
    logic              r_racc_ok;
    logic              w_racc_ok;

    logic [SUM_W-1:0]  r_colsum [NCOL];
    logic [NCOL-1:0]   r_seed;
    logic [SUM_W-1:0]  w_col_rd;
    logic              w_seed_rd;
    logic [SUM_W-1:0]  w_total;
    logic              w_seed_next;
    logic              w_fold;
    logic              w_done;
    logic [OUT_W-1:0]  w_result;

    assign w_h_ph   = hcount_in[LK-1:0];
    assign w_v_ph   = vcount_in[LK-1:0];
    assign w_col    = COL_W'(hcount_in >> LK);
    assign w_row    = ROW_W'(vcount_in >> LK);
    // Out-of-range columns (non-raster input) never touch the array.
    assign w_col_ok = (32'(hcount_in) >> LK) < 32'(NCOL);

    always_comb begin
        w_col_rd  = '0;
        w_seed_rd = 1'b0;
        if (w_col_ok) begin
            w_col_rd  = r_colsum[w_col];
            w_seed_rd = r_seed[w_col];
        end
    end

    assign w_racc_next = ((w_h_ph == '0) ? '0 : r_racc) + RACC_W'(pixel_data_in);

    // The row sum is trustworthy only once a line phase 0 has been seen since reset.
    assign w_racc_ok = (w_h_ph == '0) || r_racc_ok;

    assign w_total = ((w_v_ph == '0) ? '0 : w_col_rd) + SUM_W'(w_racc_next);

    // A column sum is complete only if every row in it was folded from a clean start
    // (v_ph==0 with a full row). This discards blocks straddling a reset.
    assign w_seed_next = w_racc_ok && ((w_v_ph == '0) || w_seed_rd);

    assign w_fold = data_valid_in && (w_h_ph == PH_LAST) && w_col_ok;
    assign w_done = w_fold && (w_v_ph == PH_LAST) && w_seed_next;

    always_comb begin
        w_result = '0;
        if (MODE == 1) begin
            w_result = OUT_W'(w_total >> (2 * LK));
        end else begin
            w_result = OUT_W'(32'(w_total) > THR_U);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_racc         <= '0;
            r_racc_ok      <= 1'b0;
            r_seed         <= '0;
            data_valid_out <= 1'b0;
            pixel_data_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
        end else begin
            data_valid_out <= w_done;
            if (data_valid_in) begin
                r_racc    <= w_racc_next;
                r_racc_ok <= w_racc_ok;
            end
            if (w_fold) begin
                r_seed[w_col] <= w_seed_next;
            end
            if (w_done) begin
                pixel_data_out <= w_result;
                hcount_out     <= w_col;
                vcount_out     <= w_row;
            end
        end
    end

    // Column sums need no reset: v_ph==0 overwrites them and r_seed gates their use.
    always_ff @(posedge clk_in) begin
        if (w_fold) begin
            r_colsum[w_col] <= w_total;
        end
    end

`ifdef BINNING_FRAME_STATS_EN
    localparam int CNT_W = $clog2(HRES * VRES / KERNEL / KERNEL + 1);

    logic [CNT_W-1:0] r_ones_cnt;
    logic             w_last;
    logic             w_one;

    assign w_last = w_done && (32'(w_col) == 32'(NCOL - 1))
                           && (32'(w_row) == 32'(VRES / KERNEL - 1));
    assign w_one  = (MODE == 0) && w_result[0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ones_cnt     <= '0;
            frame_done_out <= 1'b0;
            ones_count_out <= '0;
        end else begin
            frame_done_out <= w_last;
            if (w_last) begin
                ones_count_out <= r_ones_cnt + CNT_W'(w_one);
                r_ones_cnt     <= '0;
            end else if (w_done) begin
                r_ones_cnt <= r_ones_cnt + CNT_W'(w_one);
            end
        end
    end
`endif

endmodule

// File: tb/tb_binning_nxn.sv
// tb_binning_nxn: directed bench for binning_nxn (threshold instance 32x16 K=4, mean instance 8x4 K=2 DW=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_binning_nxn;

    localparam int H0 = 32;
    localparam int V0 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    // threshold instance
    logic [4:0] h0;
    logic [3:0] v0;
    logic       p0;
    logic       dv0;
    logic       po0;
    logic [2:0] ho0;
    logic [1:0] vo0;
    logic       dvo0;

    // mean instance
    logic [2:0] h1;
    logic [1:0] v1;
    logic [7:0] p1;
    logic       dv1;
    logic [7:0] po1;
    logic [1:0] ho1;
    logic       vo1;
    logic       dvo1;

`ifdef BINNING_FRAME_STATS_EN
    logic       fd0;
    logic [5:0] oc0;
    logic       fd1;
    logic [3:0] oc1;
`endif

    int checks   = 0;
    int failures = 0;

    binning_nxn #(.HRES(H0), .VRES(V0), .DATA_WIDTH(1), .KERNEL(4), .MODE(0), .THRESHOLD(8)) u0 (
        .clk_in(clk), .rst_in(rst), .hcount_in(h0), .vcount_in(v0),
        .pixel_data_in(p0), .data_valid_in(dv0),
        .pixel_data_out(po0), .hcount_out(ho0), .vcount_out(vo0), .data_valid_out(dvo0)
`ifdef BINNING_FRAME_STATS_EN
        , .frame_done_out(fd0), .ones_count_out(oc0)
`endif
    );

    binning_nxn #(.HRES(8), .VRES(4), .DATA_WIDTH(8), .KERNEL(2), .MODE(1), .THRESHOLD(8)) u1 (
        .clk_in(clk), .rst_in(rst), .hcount_in(h1), .vcount_in(v1),
        .pixel_data_in(p1), .data_valid_in(dv1),
        .pixel_data_out(po1), .hcount_out(ho1), .vcount_out(vo1), .data_valid_out(dvo1)
`ifdef BINNING_FRAME_STATS_EN
        , .frame_done_out(fd1), .ones_count_out(oc1)
`endif
    );

    typedef struct packed {
        logic [2:0] h;
        logic [1:0] v;
        logic       d;
    } ev0_t;

    bit   img [V0][H0];
    ev0_t q0[$];
    bit   exp_stb = 1'b0;
    bit   lat_chk = 1'b0;

    always @(negedge clk) begin
        if (!rst && dvo0) q0.push_back('{ho0, vo0, po0});
    end

`ifdef BINNING_FRAME_STATS_EN
    int fd_cnt = 0;
    always @(negedge clk) begin
        if (!rst && fd0) fd_cnt++;
    end
`endif

    // Reference for one block of the threshold instance: sum of its 16 pixels > 8.
    function automatic ev0_t exp_ev(input int bx, input int by);
        int s = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                s += int'(img[by*4+y][bx*4+x]);
        exp_ev.h = 3'(bx);
        exp_ev.v = 2'(by);
        exp_ev.d = (s > 8);
    endfunction

    // One clock of threshold-instance stimulus; checks the strobe caused by the previous cycle.
    task automatic cycle0(input bit vld, input int h, input int v, input bit pix);
        @(negedge clk);
        if (lat_chk) begin
            checks++;
            if (dvo0 !== exp_stb) begin
                failures++;
                $display("FAIL strobe_timing before h=%0d v=%0d got=%0b exp=%0b", h, v, dvo0, exp_stb);
            end
        end
        dv0 = vld;
        h0  = 5'(h);
        v0  = 4'(v);
        p0  = pix;
        exp_stb = vld && (h % 4 == 3) && (v % 4 == 3);
    endtask

    task automatic send_frame0(input bit gaps);
        for (int v = 0; v < V0; v++)
            for (int h = 0; h < H0; h++) begin
                if (gaps)
                    for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++)
                        cycle0(1'b0, h, v, 1'b0);
                cycle0(1'b1, h, v, img[v][h]);
            end
        cycle0(1'b0, 0, 0, 1'b0);
        cycle0(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dv0 = 0; h0 = '0; v0 = '0; p0 = 0;
        dv1 = 0; h1 = '0; v1 = '0; p1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dvo0, po0, ho0, vo0} !== 7'd0) begin
            failures++;
            $display("FAIL reset_u0 got=%b exp=0", {dvo0, po0, ho0, vo0});
        end
        checks++;
        if ({dvo1, po1, ho1, vo1} !== 12'd0) begin
            failures++;
            $display("FAIL reset_u1 got=%b exp=0", {dvo1, po1, ho1, vo1});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dvo0 !== 1'b0 || dvo1 !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b%b exp=00", dvo0, dvo1);
        end
    endtask

    task automatic test_all_ones;
        for (int v = 0; v < V0; v++) for (int h = 0; h < H0; h++) img[v][h] = 1'b1;
        q0.delete();
        lat_chk = 1'b1;
        send_frame0(1'b0);
        checks++;
        if (q0.size() != 32) begin
            failures++;
            $display("FAIL all_ones_count got=%0d exp=32", q0.size());
        end
        for (int i = 0; i < 32 && i < q0.size(); i++) begin
            checks++;
            if (q0[i] !== ev0_t'{3'(i % 8), 2'(i / 8), 1'b1}) begin
                failures++;
                $display("FAIL all_ones_ev%0d got=h%0d v%0d d%0b exp=h%0d v%0d d1",
                         i, q0[i].h, q0[i].v, q0[i].d, i % 8, i / 8);
            end
        end
    endtask

    task automatic test_threshold;
        ev0_t e;
        for (int v = 0; v < V0; v++) for (int h = 0; h < H0; h++) img[v][h] = 1'b0;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                img[y][x]   = 1'b1;   // block (0,0): 8 ones
                img[y][x+4] = 1'b1;   // block (1,0): 8 ones ...
            end
        img[2][4] = 1'b1;             // ... plus one = 9
        q0.delete();
        send_frame0(1'b0);
        checks++;
        if (q0.size() != 32) begin
            failures++;
            $display("FAIL thr_count got=%0d exp=32", q0.size());
        end
        checks++;
        if (q0.size() < 2 || q0[0] !== ev0_t'{3'd0, 2'd0, 1'b0} || q0[1] !== ev0_t'{3'd1, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL thr_8_vs_9 got=%0b,%0b exp=0,1",
                     (q0.size() > 0) ? q0[0].d : 1'bx, (q0.size() > 1) ? q0[1].d : 1'bx);
        end
        for (int i = 2; i < 32 && i < q0.size(); i++) begin
            e = exp_ev(i % 8, i / 8);
            checks++;
            if (q0[i] !== e) begin
                failures++;
                $display("FAIL thr_ev%0d got=%b exp=%b", i, q0[i], e);
            end
        end
    endtask

    task automatic test_gaps;
        ev0_t qa[$];
        ev0_t e;
        for (int v = 0; v < V0; v++) for (int h = 0; h < H0; h++) img[v][h] = 1'($urandom_range(1, 0));
        q0.delete();
        send_frame0(1'b0);
        qa = q0;
        q0.delete();
        send_frame0(1'b1);
        checks++;
        if (qa.size() != 32 || q0.size() != 32) begin
            failures++;
            $display("FAIL gaps_count got=%0d,%0d exp=32,32", qa.size(), q0.size());
        end
        for (int i = 0; i < 32 && i < qa.size() && i < q0.size(); i++) begin
            e = exp_ev(i % 8, i / 8);
            checks++;
            if (qa[i] !== e || q0[i] !== e) begin
                failures++;
                $display("FAIL gaps_ev%0d gapless=%b gapped=%b exp=%b", i, qa[i], q0[i], e);
            end
        end
    endtask

    task automatic test_mean;
        logic [7:0] pix [2][8];
        logic [7:0] mean [4];
        bit         e_v = 0;
        logic [7:0] e_d = 8'd0;
        logic [1:0] e_h = 2'd0;
        pix[0] = '{8'd10, 8'd20, 8'd255, 8'd255, 8'd0, 8'd0, 8'd1, 8'd2};
        pix[1] = '{8'd30, 8'd41, 8'd255, 8'd255, 8'd0, 8'd3, 8'd3, 8'd4};
        mean   = '{8'd25, 8'd255, 8'd0, 8'd2};
        for (int v = 0; v < 3; v++)
            for (int h = 0; h < 8; h++) begin
                @(negedge clk);
                if (v > 0 || h > 0) begin
                    checks++;
                    if (dvo1 !== e_v || po1 !== e_d || ho1 !== e_h || vo1 !== 1'b0) begin
                        failures++;
                        $display("FAIL mean_v%0d_h%0d got=v%0b d%0d h%0d r%0d exp=v%0b d%0d h%0d r0",
                                 v, h, dvo1, po1, ho1, vo1, e_v, e_d, e_h);
                    end
                end
                if (v == 2) break;
                dv1 = 1'b1;
                h1  = 3'(h);
                v1  = 2'(v);
                p1  = pix[v][h];
                e_v = (v == 1) && (h % 2 == 1);
                if (e_v) begin
                    e_d = mean[h / 2];
                    e_h = 2'(h / 2);
                end
            end
        dv1 = 1'b0;
    endtask

    task automatic test_reset_midframe;
        for (int v = 0; v < V0; v++) for (int h = 0; h < H0; h++) img[v][h] = 1'b1;
        lat_chk = 1'b0;
        for (int v = 0; v < V0; v++)
            for (int h = 0; h < H0; h++) begin
                if (v == 5 && h == 10) begin
                    @(negedge clk);
                    dv0 = 1'b0;
                    rst = 1'b1;
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                    q0.delete();
                end
                cycle0(1'b1, h, v, 1'b1);
            end
        cycle0(1'b0, 0, 0, 1'b0);
        cycle0(1'b0, 0, 0, 1'b0);
        checks++;
        if (q0.size() != 16) begin
            failures++;
            $display("FAIL rst_mid_count got=%0d exp=16", q0.size());
        end
        checks++;
        if (q0.size() == 0 || q0[0] !== ev0_t'{3'd0, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_first got=%b exp=%b", (q0.size() > 0) ? q0[0] : 6'bx, ev0_t'{3'd0, 2'd2, 1'b1});
        end
        checks++;
        if (q0.size() == 0 || q0[q0.size()-1] !== ev0_t'{3'd7, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_last got=%b exp=%b", (q0.size() > 0) ? q0[q0.size()-1] : 6'bx, ev0_t'{3'd7, 2'd3, 1'b1});
        end
        exp_stb = 1'b0;
        lat_chk = 1'b1;
    endtask

`ifdef BINNING_FRAME_STATS_EN
    task automatic test_frame_stats;
        for (int v = 0; v < V0; v++)
            for (int h = 0; h < H0; h++)
                img[v][h] = (((h / 4) + (v / 4)) % 2 == 0);
        fd_cnt = 0;
        send_frame0(1'b0);
        checks++;
        if (fd_cnt != 1) begin
            failures++;
            $display("FAIL frame_done_pulses got=%0d exp=1", fd_cnt);
        end
        checks++;
        if (oc0 !== 6'd16) begin
            failures++;
            $display("FAIL ones_count got=%0d exp=16", oc0);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_all_ones();
        test_threshold();
        test_gaps();
        test_mean();
        test_reset_midframe();
`ifdef BINNING_FRAME_STATS_EN
        test_frame_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
